// File: rtl/cuca_pkg.sv
// Shared cuca types: bus width, memory depth, ALU op and memory responder state.
// Also holds the wait-counter width and its load-value helper.
package cuca_pkg;

  localparam int CUCA_BITW      = 8;
  localparam int CUCA_MEM_DEPTH = 256;
  localparam int CUCA_WAIT_W    = 4;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_PASS
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // The IDLE cycle that accepts a request already counts as one wait
  // cycle, so WAIT lasts cycles-1 cycles and the counter starts at cycles-2.
  function automatic logic [CUCA_WAIT_W-1:0] wait_load(input int cycles);
    return (cycles >= 2) ? CUCA_WAIT_W'(cycles - 2) : '0;
  endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Loadable down-counter with zero flag, used for memory wait states.
// Ports: clock, n_reset, i_load, i_load_val, i_dec, o_zero.
module mem_wait_ctr #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         n_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/bus_mem.sv
// Bus-attached memory: MAR loaded from bus, read/write via mem_rd/mem_wr.
// Ports: clock, n_reset, bus(inout), mar_wr, mem_rd, mem_wr, ready, err.
// Option: CUCA_MEM_WAIT_EN adds WAIT_CYCLES wait states per access.
module bus_mem
  import cuca_pkg::*;
#(
  parameter int BITW        = CUCA_BITW,
  parameter int DEPTH       = CUCA_MEM_DEPTH,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clock,
  input  logic            n_reset,
  inout  wire  [BITW-1:0] bus,
  input  logic            mar_wr,
  input  logic            mem_rd,
  input  logic            mem_wr,
  output logic            ready,
  output logic            err
);

  localparam int AW = $clog2(DEPTH);

  logic [BITW-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_mar;
  logic            r_err;

  logic            w_rd_req;
  logic            w_wr_req;
  logic            w_conflict;
  logic            w_idle;
  logic            w_drive;
  logic            w_we;
  logic [AW-1:0]   w_addr;

  assign w_rd_req   = mem_rd & ~mem_wr;
  assign w_wr_req   = mem_wr & ~mem_rd;
  assign w_conflict = mem_rd & mem_wr;

`ifdef CUCA_MEM_WAIT_EN

  mem_state_t    r_state;
  mem_state_t    w_state_nxt;
  logic          r_is_wr;
  logic [AW-1:0] r_addr;
  logic          w_load;
  logic          w_dec;
  logic          w_zero;
  logic          w_hold;

  mem_wait_ctr #(
    .W(CUCA_WAIT_W)
  ) u_wait_ctr (
    .clock     (clock),
    .n_reset   (n_reset),
    .i_load    (w_load),
    .i_load_val(wait_load(WAIT_CYCLES)),
    .i_dec     (w_dec),
    .o_zero    (w_zero)
  );

  // The access continues only while the same kind of request is held.
  assign w_hold = r_is_wr ? w_wr_req : w_rd_req;
  assign w_idle = (r_state == IDLE);
  // Address captured at acceptance so a same-cycle mar_wr
  // only affects later accesses.
  assign w_addr = r_addr;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    ready       = 1'b0;
    w_drive     = 1'b0;
    w_we        = 1'b0;
    unique case (r_state)
      IDLE: begin
        ready = ~(w_rd_req | w_wr_req);
        if (w_rd_req | w_wr_req) begin
          w_load      = 1'b1;
          w_state_nxt = (WAIT_CYCLES > 1) ? WAIT : DONE;
        end
      end
      WAIT: begin
        if (!w_hold) begin
          w_state_nxt = IDLE;
        end else if (w_zero) begin
          w_state_nxt = DONE;
        end else begin
          w_dec = 1'b1;
        end
      end
      DONE: begin
        ready       = 1'b1;
        w_state_nxt = IDLE;
        w_drive     = w_hold & ~r_is_wr;
        w_we        = w_hold & r_is_wr;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!n_reset) begin
      ready   = 1'b1;
      w_drive = 1'b0;
      w_we    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
      r_is_wr <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && (w_rd_req | w_wr_req)) begin
        r_is_wr <= w_wr_req;
        r_addr  <= r_mar;
      end
    end
  end

`else

  logic w_unused_cfg;

  assign w_unused_cfg = |WAIT_CYCLES;
  assign ready        = 1'b1;
  assign w_idle       = 1'b1;
  assign w_addr       = r_mar;
  assign w_drive      = n_reset & w_rd_req;
  assign w_we         = n_reset & w_wr_req;

`endif

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_mar <= '0;
      r_err <= 1'b0;
    end else begin
      if (mar_wr && w_idle) begin
        r_mar <= bus[AW-1:0];
      end
      if (w_conflict) begin
        r_err <= 1'b1;
      end
    end
  end

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge clock) begin
    if (w_we) begin
      r_mem[w_addr] <= bus;
    end
  end

  assign bus = w_drive ? r_mem[w_addr] : 'z;
  assign err = r_err;

endmodule

// File: tb/tb_bus_mem.sv
// Self-checking bench for bus_mem against an array model of the memory.
// bus has a pullup, so an undriven bus reads as all ones.
module tb_bus_mem;

  localparam int BW    = 8;
  localparam int DEPTH = 16;
  localparam int WC    = 2;
`ifdef CUCA_MEM_WAIT_EN
  localparam int LAT = WC + 1;
`else
  localparam int LAT = 1;
`endif
  localparam logic [7:0] ZV = 8'hFF;

  logic clock = 1'b0;
  logic n_reset;
  logic mar_wr;
  logic mem_rd;
  logic mem_wr;
  logic ready;
  logic err;
  logic [7:0] drv;
  logic drv_en;
  wire [7:0] bus;

  pullup (bus[0]);
  pullup (bus[1]);
  pullup (bus[2]);
  pullup (bus[3]);
  pullup (bus[4]);
  pullup (bus[5]);
  pullup (bus[6]);
  pullup (bus[7]);

  assign bus = drv_en ? drv : 'z;

  always #5 clock = ~clock;

  bus_mem #(
    .BITW       (BW),
    .DEPTH      (DEPTH),
    .WAIT_CYCLES(WC)
  ) dut (
    .clock  (clock),
    .n_reset(n_reset),
    .bus    (bus),
    .mar_wr (mar_wr),
    .mem_rd (mem_rd),
    .mem_wr (mem_wr),
    .ready  (ready),
    .err    (err)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] m_mem [DEPTH];
  int m_mar = 0;

  int lat;
  logic [7:0] rd;
  bit zb;

  // Tasks enter and leave 1 time unit after a rising edge.
  task automatic load_mar(input logic [7:0] a);
    mar_wr = 1'b1;
    drv = a;
    drv_en = 1'b1;
    @(posedge clock); #1;
    mar_wr = 1'b0;
    drv_en = 1'b0;
    m_mar = int'(a) % DEPTH;
  endtask

  task automatic access(input bit wr, input logic [7:0] d, input bit with_mar,
                        output int l, output logic [7:0] r, output bit zbad);
    mem_rd = !wr;
    mem_wr = wr;
    mar_wr = with_mar;
    drv = d;
    drv_en = wr;
    l = -1;
    r = 'x;
    zbad = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (ready === 1'b1) begin
        if (!wr) r = bus;
        l = n + 1;
        break;
      end
      if (!wr && bus !== ZV) zbad = 1'b1;
      @(posedge clock); #1;
      mar_wr = 1'b0;
    end
    @(posedge clock); #1;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    mar_wr = 1'b0;
    drv_en = 1'b0;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    mem_rd = 1'b1;
    #2;
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", ready); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    n_chk++; if (bus !== ZV) begin n_fail++; $display("FAIL rst_busz: got %h want %h", bus, ZV); end
    @(posedge clock); #1;
    mem_rd = 1'b0;
    n_reset = 1'b1;
    m_mar = 0;
  endtask

  task automatic test_write_read();
    load_mar(8'h05);
    access(1'b1, 8'hA7, 1'b0, lat, rd, zb);
    m_mem[m_mar] = 8'hA7;
    n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL wr_lat: got %0d want %0d", lat, LAT); end
    @(negedge clock);
    n_chk++; if (bus !== ZV) begin n_fail++; $display("FAIL pre_rd_busz: got %h want %h", bus, ZV); end
    @(posedge clock); #1;
    access(1'b0, 8'h00, 1'b0, lat, rd, zb);
    n_chk++; if (rd !== 8'hA7) begin n_fail++; $display("FAIL rd_data: got %h want a7", rd); end
    n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL rd_lat: got %0d want %0d", lat, LAT); end
    n_chk++; if (zb !== 1'b0) begin n_fail++; $display("FAIL rd_wait_busz: got %b want 0", zb); end
    @(negedge clock);
    n_chk++; if (bus !== ZV) begin n_fail++; $display("FAIL post_rd_busz: got %h want %h", bus, ZV); end
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL post_rd_ready: got %b want 1", ready); end
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      load_mar(8'(i));
      d = 8'($urandom_range(0, 254));
      access(1'b1, d, 1'b0, lat, rd, zb);
      m_mem[m_mar] = d;
      n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL fill_lat: got %0d want %0d", lat, LAT); end
    end
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: load_mar(8'($urandom_range(0, 255)));
        1: begin
          d = 8'($urandom_range(0, 254));
          access(1'b1, d, 1'b0, lat, rd, zb);
          m_mem[m_mar] = d;
          n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL rnd_wr_lat: got %0d want %0d", lat, LAT); end
        end
        default: begin
          access(1'b0, 8'h00, 1'b0, lat, rd, zb);
          n_chk++; if (rd !== m_mem[m_mar]) begin n_fail++; $display("FAIL rnd_rd @%0d: got %h want %h", m_mar, rd, m_mem[m_mar]); end
          n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL rnd_rd_lat: got %0d want %0d", lat, LAT); end
          n_chk++; if (zb !== 1'b0) begin n_fail++; $display("FAIL rnd_rd_busz: got %b want 0", zb); end
        end
      endcase
    end
  endtask

  task automatic test_same_cycle_mar();
    load_mar(8'h02);
    access(1'b1, 8'h09, 1'b1, lat, rd, zb);
    m_mem[2] = 8'h09;
    m_mar = 9;
    access(1'b0, 8'h00, 1'b0, lat, rd, zb);
    n_chk++; if (rd !== m_mem[9]) begin n_fail++; $display("FAIL mar_new: got %h want %h", rd, m_mem[9]); end
    load_mar(8'h02);
    access(1'b0, 8'h00, 1'b0, lat, rd, zb);
    n_chk++; if (rd !== 8'h09) begin n_fail++; $display("FAIL mar_old_wr: got %h want 09", rd); end
  endtask

  task automatic test_abort();
    load_mar(8'h10);
    access(1'b1, 8'h3C, 1'b0, lat, rd, zb);
    m_mem[m_mar] = 8'h3C;
    drv = 8'hFF;
    drv_en = 1'b1;
    @(posedge clock); #1;
    drv_en = 1'b0;
`ifdef CUCA_MEM_WAIT_EN
    mem_wr = 1'b1;
    drv_en = 1'b1;
    @(negedge clock);
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL abort_c0_ready: got %b want 0", ready); end
    @(posedge clock); #1;
    mem_wr = 1'b0;
    drv_en = 1'b0;
    @(negedge clock);
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL abort_c1_ready: got %b want 0", ready); end
    @(posedge clock); #1;
    @(negedge clock);
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL abort_idle_ready: got %b want 1", ready); end
    @(posedge clock); #1;
`endif
    access(1'b0, 8'h00, 1'b0, lat, rd, zb);
    n_chk++; if (rd !== 8'h3C) begin n_fail++; $display("FAIL abort_keep: got %h want 3c", rd); end
  endtask

  task automatic test_conflict();
    mem_rd = 1'b1;
    mem_wr = 1'b1;
    drv_en = 1'b0;
    @(negedge clock);
    n_chk++; if (bus !== ZV) begin n_fail++; $display("FAIL conf_busz: got %h want %h", bus, ZV); end
    @(posedge clock); #1;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL conf_err: got %b want 1", err); end
    access(1'b0, 8'h00, 1'b0, lat, rd, zb);
    n_chk++; if (rd !== m_mem[m_mar]) begin n_fail++; $display("FAIL conf_mem: got %h want %h", rd, m_mem[m_mar]); end
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL conf_sticky: got %b want 1", err); end
    n_reset = 1'b0;
    #1;
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL conf_clr: got %b want 0", err); end
    @(posedge clock); #1;
    n_reset = 1'b1;
    m_mar = 0;
  endtask

  task automatic test_reset_mid();
    load_mar(8'h00);
    access(1'b1, 8'h4B, 1'b0, lat, rd, zb);
    m_mem[0] = 8'h4B;
    load_mar(8'h07);
    access(1'b1, 8'h21, 1'b0, lat, rd, zb);
    m_mem[7] = 8'h21;
    mem_wr = 1'b1;
    drv = 8'h55;
    drv_en = 1'b1;
`ifdef CUCA_MEM_WAIT_EN
    @(posedge clock); #1;
`endif
    #2;
    n_reset = 1'b0;
    drv_en = 1'b0;
    #1;
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", ready); end
    n_chk++; if (bus !== ZV) begin n_fail++; $display("FAIL rmid_busz: got %h want %h", bus, ZV); end
    mem_wr = 1'b0;
    @(posedge clock); #1;
    n_reset = 1'b1;
    m_mar = 0;
    access(1'b0, 8'h00, 1'b0, lat, rd, zb);
    n_chk++; if (rd !== 8'h4B) begin n_fail++; $display("FAIL rmid_mar0: got %h want 4b", rd); end
    load_mar(8'h07);
    access(1'b0, 8'h00, 1'b0, lat, rd, zb);
    n_chk++; if (rd !== 8'h21) begin n_fail++; $display("FAIL rmid_keep: got %h want 21", rd); end
  endtask

  task automatic test_truncation();
    load_mar(8'h13);
    access(1'b1, 8'h99, 1'b0, lat, rd, zb);
    m_mem[m_mar] = 8'h99;
    load_mar(8'h03);
    access(1'b0, 8'h00, 1'b0, lat, rd, zb);
    n_chk++; if (rd !== 8'h99) begin n_fail++; $display("FAIL trunc: got %h want 99", rd); end
  endtask

  initial begin
    n_reset = 1'b0;
    mar_wr = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    drv = 8'h00;
    drv_en = 1'b0;
    test_reset();
    test_write_read();
    test_random();
    test_same_cycle_mar();
    test_abort();
    test_conflict();
    test_reset_mid();
    test_truncation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
